// File: rtl/scc_mem_ctrl.sv
// Unified single-ported instruction/data memory controller.
// One access at a time: a fetch or a data read/write is captured in IDLE,
// waits WAIT_STATES cycles, then completes with a one-cycle ready pulse.
// Faulting accesses (misaligned, out of range, read+write together) are
// suppressed, return zero and set sticky error bits.
module scc_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt_f,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_ready,
  output logic [DATA_W-1:0] imem_rdata,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_ready,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        err_bits
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, IACC, DACC, HALT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              accept_i, accept_d;
  logic              done_i, done_d;

  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              rd_p0, wr_p0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic              fault_misc;
  logic              fault_range;
  logic              access_ok;

  logic              imem_ready_q, dmem_ready_q;
  logic [1:0]        err_q;

  // Decode of the captured request: fault classification and word index
  assign idx         = addr_p0[DEPTH_LOG2+1:2];
  assign fault_misc  = (addr_p0[1:0] != 2'b00) || (rd_p0 && wr_p0);
  assign fault_range = (addr_p0 >> (DEPTH_LOG2 + 2)) != '0;
  assign access_ok   = !fault_misc && !fault_range;

  // Next-state logic: arbitration in IDLE, wait countdown during an access
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_i = 1'b0;
    accept_d = 1'b0;
    done_i   = 1'b0;
    done_d   = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (halt_f) begin
            state_d = HALT;
          end else if (dmem_read || dmem_write) begin
            state_d  = DACC;
            cnt_d    = 3'(WAIT_STATES);
            accept_d = 1'b1;
          end else if (imem_req) begin
            state_d  = IACC;
            cnt_d    = 3'(WAIT_STATES);
            accept_i = 1'b1;
          end
        end
        IACC: begin
          if (cnt_q == 3'd0) begin
            state_d = IDLE;
            done_i  = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        DACC: begin
          if (cnt_q == 3'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture stage: request is latched on acceptance so later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept_d) begin
      addr_p0  <= dmem_addr;
      wdata_p0 <= dmem_wdata;
      rd_p0    <= dmem_read;
      wr_p0    <= dmem_write;
    end else if (accept_i) begin
      addr_p0  <= imem_addr;
      wdata_p0 <= wdata_p0;
      rd_p0    <= 1'b1;
      wr_p0    <= 1'b0;
    end
  end

  // Memory write port: only a clean data write, and never when reset aborts it
  always_ff @(posedge clk) begin
    if (!rst && done_d && access_ok && wr_p0) begin
      mem[idx] <= wdata_p0;
    end
  end

  // Read data registers: updated only on completion, zero for faulting or write accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      if (done_i) begin
        imem_rdata <= access_ok ? mem[idx] : '0;
      end
      if (done_d) begin
        dmem_rdata <= (access_ok && rd_p0 && !wr_p0) ? mem[idx] : '0;
      end
    end
  end

  // Ready pulses and sticky error bits; ready holds across disabled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      err_q        <= 2'b00;
    end else if (clk_en) begin
      imem_ready_q <= done_i;
      dmem_ready_q <= done_d;
      if (done_i || done_d) begin
        err_q <= err_q | {fault_range, fault_misc};
      end
    end
  end

  // A pending ready pulse is only shown in an enabled cycle, so it lasts one advance
  assign imem_ready = imem_ready_q & clk_en;
  assign dmem_ready = dmem_ready_q & clk_en;
  assign err_bits   = err_q;
  assign busy       = (state_q == IACC) || (state_q == DACC);
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_scc_mem_ctrl.sv
// Bench for scc_mem_ctrl: directed scenarios plus a randomized phase, with a
// reference model predicting each completion and a monitor checking it.
module tb_scc_mem_ctrl;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int WS         = 2;

  logic              clk = 1'b0;
  logic              rst, clk_en, halt_f;
  logic              imem_req, dmem_read, dmem_write;
  logic [ADDR_W-1:0] imem_addr, dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, imem_rdata, dmem_rdata;
  logic              imem_ready, dmem_ready, busy, halted;
  logic [1:0]        err_bits;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_mem [int];
  logic [1:0]  mdl_err = 2'b00;
  bit          rand_ce = 1'b0;

  scc_mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .busy(busy), .halted(halted), .err_bits(err_bits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a word store plus sticky error flags, applied per access
  function automatic exp_t predict(input bit is_d, input bit rd, input bit wr,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit   f0, f1;
    int   w;
    f0 = (a % 4 != 0) || (is_d && rd && wr);
    f1 = (a / 4) >= (1 << DEPTH_LOG2);
    w  = int'(a / 4);
    mdl_err = mdl_err | {f1, f0};
    e.is_d  = is_d;
    e.err   = mdl_err;
    e.rdata = 32'h0;
    if (!f0 && !f1) begin
      if (is_d && wr) mdl_mem[w] = wd;
      else if (mdl_mem.exists(w)) e.rdata = mdl_mem[w];
    end
    return e;
  endfunction

  task automatic drop_reqs();
    imem_req = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
  endtask

  // One requester transaction: hold the request until the matching ready
  task automatic do_op(input bit is_d, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input int ce_gap, input string name);
    int lat;
    bit got;
    sb.push_back(predict(is_d, rd, wr, a, wd));
    @(negedge clk);
    if (is_d) begin
      dmem_read = rd; dmem_write = wr; dmem_addr = a; dmem_wdata = wd;
    end else begin
      imem_req = 1'b1; imem_addr = a;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && exp_lat >= 0 && ce_gap == 0) begin
        dmem_addr = a ^ 32'h4; dmem_wdata = ~wd; imem_addr = a ^ 32'h4;
      end
      if (ce_gap > 0 && lat == 1) clk_en = 1'b0;
      if (ce_gap > 0 && lat == 1 + ce_gap) clk_en = 1'b1;
      got = is_d ? dmem_ready : imem_ready;
    end
    drop_reqs();
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    else if (exp_lat >= 0) chk({name, "_lat"}, lat, exp_lat);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_imem_ready"}, imem_ready, 0);
    chk({name, "_dmem_ready"}, dmem_ready, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_halted"}, halted, 0);
    chk({name, "_err"}, err_bits, 0);
    chk({name, "_imem_rdata"}, imem_rdata, 0);
    chk({name, "_dmem_rdata"}, dmem_rdata, 0);
  endtask

  // Random clock-enable pattern, changed just after the edge
  always begin
    @(posedge clk);
    #1;
    if (rand_ce) clk_en = ($urandom_range(0, 3) != 0);
  end

  // Monitor: every ready must match the oldest predicted completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (imem_ready || dmem_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ready_port", dmem_ready, e.is_d);
          chk("rdata", e.is_d ? dmem_rdata : imem_rdata, e.rdata);
          chk("err_bits", err_bits, e.err);
        end
      end
    end
  end

  initial begin
    int lat, gap;
    bit got;
    rst = 1'b1; clk_en = 1'b1; halt_f = 1'b0;
    drop_reqs();
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    // Basic write then read-back with fixed latency
    do_op(1, 0, 1, 32'h40, 32'hDEADBEEF, WS + 2, 0, "wr40");
    do_op(1, 1, 0, 32'h40, 32'h0, WS + 2, 0, "rd40");

    // Fill a small region, then a randomized mix with random clock enable
    for (int i = 0; i < 32; i++) do_op(1, 0, 1, 32'(i * 4), $urandom, WS + 2, 0, "fill");
    do_op(0, 0, 0, 32'h40, 32'h0, WS + 2, 0, "fetch40");
    @(negedge clk);
    rand_ce = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int kind;
      logic [31:0] ra;
      kind = $urandom_range(0, 2);
      ra   = 32'($urandom_range(0, 31) * 4);
      do_op(kind != 0, kind == 1, kind == 2, ra, $urandom, -1, 0, "rand");
    end
    @(negedge clk);
    rand_ce = 1'b0;
    clk_en  = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous fetch and data read: data wins, fetch follows
    sb.push_back(predict(1, 1, 0, 32'h10, 32'h0));
    sb.push_back(predict(0, 0, 0, 32'h20, 32'h0));
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h20; dmem_read = 1'b1; dmem_addr = 32'h10;
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++; got = dmem_ready;
    end
    dmem_read = 1'b0;
    chk("prio_dmem_lat", lat, WS + 2);
    chk("prio_no_imem", imem_ready, 0);
    gap = 0; got = 1'b0;
    while (!got && gap < 100) begin
      @(negedge clk); gap++; got = imem_ready;
    end
    imem_req = 1'b0;
    chk("prio_imem_gap", gap, WS + 2);

    // Clock enable held low for five cycles in the middle of an access
    do_op(1, 1, 0, 32'h40, 32'h0, WS + 2 + 5, 5, "ce_gap");

    // Reset one cycle before a write completes aborts it
    do_op(1, 0, 1, 32'h80, 32'h11112222, WS + 2, 0, "wr80_old");
    @(negedge clk);
    dmem_write = 1'b1; dmem_addr = 32'h80; dmem_wdata = 32'h99998888;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drop_reqs();
    mdl_err = 2'b00;
    chk_reset("abort");
    repeat (6) @(negedge clk);
    do_op(1, 1, 0, 32'h80, 32'h0, WS + 2, 0, "rd80_old");

    // Error handling: misaligned, out of range, illegal command, suppressed writes
    do_op(1, 1, 0, 32'h42, 32'h0, WS + 2, 0, "rd_misaligned");
    do_op(1, 1, 0, 32'h1000, 32'h0, WS + 2, 0, "rd_oor");
    do_op(1, 1, 1, 32'h44, 32'h5555AAAA, WS + 2, 0, "rd_wr_both");
    do_op(0, 0, 0, 32'h2, 32'h0, WS + 2, 0, "fetch_misaligned");
    do_op(1, 0, 1, 32'h1040, 32'hBAD0BAD0, WS + 2, 0, "wr_oor");
    do_op(1, 0, 1, 32'h41, 32'hBAD1BAD1, WS + 2, 0, "wr_misaligned");
    do_op(1, 1, 0, 32'h40, 32'h0, WS + 2, 0, "rd40_after_err");
    chk("err_sticky", err_bits, 2'b11);

    // Halt request during a data access
    sb.push_back(predict(1, 1, 0, 32'h40, 32'h0));
    @(negedge clk);
    dmem_read = 1'b1; dmem_addr = 32'h40;
    @(negedge clk);
    halt_f = 1'b1;
    chk("halt_busy", busy, 1);
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++; got = dmem_ready;
    end
    dmem_read = 1'b0;
    chk("halt_access_done", got, 1);
    @(negedge clk);
    chk("halted", halted, 1);
    imem_req = 1'b1; imem_addr = 32'h0;
    repeat (10) @(negedge clk);
    chk("halt_still", halted, 1);
    chk("halt_not_busy", busy, 0);
    imem_req = 1'b0; halt_f = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_err = 2'b00;
    chk("unhalt", halted, 0);
    chk("err_cleared", err_bits, 2'b00);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
